axi_lite_sram_slave: RTL

AXI4-lite slave that terminates the memory-side AXI bus and drives a single-port synchronous SRAM macro. It sits directly downstream of the core's SRAM-to-AXI adapter and provides the on-chip instruction/data RAM. It accepts one transaction at a time, decodes an address window, and returns SLVERR for out-of-window or disallowed accesses so bus faults reach the core.

---
 rtl/axi_lite_sram_slave.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_sram_slave.sv
// AXI4-lite slave fronting a single-port synchronous SRAM macro.
// One transaction in flight; out-of-window or denied accesses answer SLVERR.
module axi_lite_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES = 4096,
  parameter bit          EXEC_OK    = 1'b1,
  localparam int unsigned AW        = $clog2(SIZE_BYTES / 4)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [31:0]   s_axi_awaddr,
  input  logic [2:0]    s_axi_awprot,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  input  logic [31:0]   s_axi_wdata,
  input  logic [3:0]    s_axi_wstrb,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  output logic [1:0]    s_axi_bresp,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  input  logic [31:0]   s_axi_araddr,
  input  logic [2:0]    s_axi_arprot,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  output logic [1:0]    s_axi_rresp,
  output logic [31:0]   s_axi_rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic [3:0]    sram_wstrb,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_EXEC = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_EXEC = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            aw_held_r, w_held_r;
  logic [31:0]     awaddr_r, wdata_r;
  logic [3:0]      wstrb_r;
  logic            err_r, err_nxt_s;
  logic            cen_r, cen_nxt_s, wen_r, wen_nxt_s;
  logic [AW-1:0]   addr_r, addr_nxt_s;
  logic [31:0]     sram_wdata_r, wdata_nxt_s;
  logic [3:0]      sram_wstrb_r, wstrb_nxt_s;
  logic            bvalid_r, rvalid_r;
  logic [1:0]      bresp_r, rresp_r;

  logic            aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, wr_go_s;
  logic [31:0]     wr_addr_s, wr_data_s, wr_off_s, rd_off_s;
  logic [3:0]      wr_strb_s;
  logic            wr_ok_s, rd_ok_s;
  logic            unused_s;

  // Unsigned offset compare: addresses below the base wrap to a huge offset.
  function automatic logic in_window(input logic [31:0] off);
    return (off < SIZE_BYTES);
  endfunction

  assign s_axi_awready = (state_r == ST_IDLE) && !aw_held_r;
  assign s_axi_wready  = (state_r == ST_IDLE) && !w_held_r;
  assign s_axi_arready = (state_r == ST_IDLE) && !aw_held_r && !w_held_r &&
                         !s_axi_awvalid && !s_axi_wvalid;

  assign aw_hs_s = s_axi_awvalid && s_axi_awready;
  assign w_hs_s  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs_s = s_axi_arvalid && s_axi_arready;
  assign b_hs_s  = bvalid_r && s_axi_bready;
  assign wr_go_s = (state_r == ST_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);

  // A same-cycle handshake bypasses the holding registers.
  assign wr_addr_s = aw_hs_s ? s_axi_awaddr : awaddr_r;
  assign wr_data_s = w_hs_s  ? s_axi_wdata  : wdata_r;
  assign wr_strb_s = w_hs_s  ? s_axi_wstrb  : wstrb_r;
  assign wr_off_s  = wr_addr_s - BASE_ADDR;
  assign rd_off_s  = s_axi_araddr - BASE_ADDR;
  assign wr_ok_s   = in_window(wr_off_s);
  assign rd_ok_s   = in_window(rd_off_s) && !((EXEC_OK == 1'b0) && s_axi_arprot[2]);

  assign unused_s = ^{s_axi_awprot, s_axi_arprot[1:0], wr_off_s, rd_off_s};

  // Next state plus the SRAM command for the cycle that follows.
  always_comb begin
    state_nxt_s = state_r;
    err_nxt_s   = err_r;
    cen_nxt_s   = 1'b0;
    wen_nxt_s   = 1'b0;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = sram_wdata_r;
    wstrb_nxt_s = sram_wstrb_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_go_s) begin
          state_nxt_s = ST_WR_EXEC;
          err_nxt_s   = !wr_ok_s;
          cen_nxt_s   = wr_ok_s && (wr_strb_s != 4'h0);
          wen_nxt_s   = wr_ok_s && (wr_strb_s != 4'h0);
          addr_nxt_s  = wr_off_s[AW+1:2];
          wdata_nxt_s = wr_data_s;
          wstrb_nxt_s = wr_strb_s;
        end else if (ar_hs_s) begin
          state_nxt_s = ST_RD_EXEC;
          err_nxt_s   = !rd_ok_s;
          cen_nxt_s   = rd_ok_s;
          wen_nxt_s   = 1'b0;
          addr_nxt_s  = rd_off_s[AW+1:2];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_EXEC: state_nxt_s = ST_WR_RESP;
      ST_WR_RESP: begin
        if (s_axi_bready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      ST_RD_EXEC: state_nxt_s = ST_RD_RESP;
      ST_RD_RESP: begin
        if (s_axi_rready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, SRAM command and response registers.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r      <= ST_IDLE;
      err_r        <= 1'b0;
      cen_r        <= 1'b0;
      wen_r        <= 1'b0;
      addr_r       <= '0;
      sram_wdata_r <= 32'h0;
      sram_wstrb_r <= 4'h0;
      bvalid_r     <= 1'b0;
      rvalid_r     <= 1'b0;
      bresp_r      <= 2'b00;
      rresp_r      <= 2'b00;
    end else begin
      state_r      <= state_nxt_s;
      err_r        <= err_nxt_s;
      cen_r        <= cen_nxt_s;
      wen_r        <= wen_nxt_s;
      addr_r       <= addr_nxt_s;
      sram_wdata_r <= wdata_nxt_s;
      sram_wstrb_r <= wstrb_nxt_s;
      bvalid_r     <= (state_nxt_s == ST_WR_RESP);
      rvalid_r     <= (state_nxt_s == ST_RD_RESP);
      bresp_r      <= ((state_nxt_s == ST_WR_RESP) && err_nxt_s) ? 2'b10 : 2'b00;
      rresp_r      <= ((state_nxt_s == ST_RD_RESP) && err_nxt_s) ? 2'b10 : 2'b00;
    end
  end

  // Write address/data holding registers, released by the B handshake.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awaddr_r  <= 32'h0;
      wdata_r   <= 32'h0;
      wstrb_r   <= 4'h0;
    end else if (b_hs_s) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        awaddr_r  <= s_axi_awaddr;
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        wdata_r  <= s_axi_wdata;
        wstrb_r  <= s_axi_wstrb;
      end
    end
  end

  assign sram_cen     = cen_r;
  assign sram_wen     = wen_r;
  assign sram_addr    = addr_r;
  assign sram_wdata   = sram_wdata_r;
  assign sram_wstrb   = sram_wstrb_r;
  assign s_axi_bvalid = bvalid_r;
  assign s_axi_bresp  = bresp_r;
  assign s_axi_rvalid = rvalid_r;
  assign s_axi_rresp  = rresp_r;
  // SRAM data is held until the next access, so a stalled R beat stays stable.
  assign s_axi_rdata  = (rvalid_r && (rresp_r == 2'b00)) ? sram_rdata : 32'h0;

endmodule
